// File: rtl/gamepad_pmod_rx.sv
// gamepad_pmod_rx: synchronise, deserialise and validate Gamepad Pmod frames into registered button levels
module gamepad_pmod_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_BITS       = 12,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pmod_data,
  input  logic pmod_clk,
  input  logic pmod_latch,
  output logic b,
  output logic y,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic a,
  output logic x,
  output logic l,
  output logic r,
  output logic is_present,
  output logic frame_valid,
  output logic frame_error,
  output logic start_pressed
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 2);
  logic [SYNC_STAGES-1:0] data_sync_q, clk_sync_q, latch_sync_q;
  logic clk_prev_q, latch_prev_q, clk_rise, latch_rise;
  logic [NUM_BITS-1:0] shift_q, shift_d, shift_nx, pend_frame_q, pend_frame_d;
  logic [3:0] count_q, count_d, count_nx;
  logic pend_q, pend_d, pend_ok_q, pend_ok_d;
  logic accept, nocon, ctrl, timeout;
  logic [11:0] btn_q, btn_d;
  logic present_q, present_d, valid_q, valid_d, error_q, error_d;
  logic sp_q, sp_d, start_last_q, start_last_d;
  logic [WDW-1:0] wd_q, wd_d;
  // Next-state: shift before latch check so a coincident clock edge's bit is part of the frame
  always_comb begin
    clk_rise     = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    latch_rise   = latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;
    shift_nx     = clk_rise ? {shift_q[NUM_BITS-2:0], data_sync_q[SYNC_STAGES-1]} : shift_q;
    count_nx     = (clk_rise && count_q != 4'hF) ? count_q + 4'd1 : count_q;
    shift_d      = latch_rise ? '0 : shift_nx;
    count_d      = latch_rise ? '0 : count_nx;
    pend_d       = latch_rise;
    pend_ok_d    = latch_rise && count_nx == 4'(NUM_BITS);
    pend_frame_d = shift_nx;
    accept       = pend_q & pend_ok_q;
    nocon        = accept & (&pend_frame_q);
    ctrl         = accept & ~nocon;
    timeout      = present_q && wd_q == WD_LAST;
    btn_d        = ctrl ? pend_frame_q[11:0] : (nocon || timeout) ? 12'h000 : btn_q;
    present_d    = ctrl ? 1'b1 : (nocon || timeout) ? 1'b0 : present_q;
    wd_d         = ctrl ? '0 : present_q ? wd_q + WDW'(1) : wd_q;
    valid_d      = accept;
    error_d      = pend_q & ~pend_ok_q;
    sp_d         = ctrl & pend_frame_q[8] & ~start_last_q;
    start_last_d = accept ? ctrl & pend_frame_q[8] : start_last_q;
  end
  // State registers, including the synchroniser chains and edge-detect history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_sync_q  <= '0;
      clk_sync_q   <= '0;
      latch_sync_q <= '0;
      clk_prev_q   <= 1'b0;
      latch_prev_q <= 1'b0;
      shift_q      <= '0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      pend_ok_q    <= 1'b0;
      pend_frame_q <= '0;
      btn_q        <= '0;
      present_q    <= 1'b0;
      wd_q         <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      sp_q         <= 1'b0;
      start_last_q <= 1'b0;
    end else begin
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], pmod_data};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], pmod_clk};
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pmod_latch};
      clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
      latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
      shift_q      <= shift_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      pend_ok_q    <= pend_ok_d;
      pend_frame_q <= pend_frame_d;
      btn_q        <= btn_d;
      present_q    <= present_d;
      wd_q         <= wd_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      sp_q         <= sp_d;
      start_last_q <= start_last_d;
    end
  end
  assign {b, y, select, start, up, down, left, right, a, x, l, r} = btn_q;
  assign is_present    = present_q;
  assign frame_valid   = valid_q;
  assign frame_error   = error_q;
  assign start_pressed = sp_q;
endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// tb_gamepad_pmod_rx: scoreboard bench driving directed Pmod frames into gamepad_pmod_rx
module tb_gamepad_pmod_rx;
  logic clk = 1'b0, rst_n = 1'b0, pmod_data = 1'b0, pmod_clk = 1'b0, pmod_latch = 1'b0;
  logic b, y, select, start, up, down, left, right, a, x, l, r;
  logic is_present, frame_valid, frame_error, start_pressed;
  logic [11:0] btn;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {
    logic [11:0] btn;
    logic        present;
    logic        valid;
    logic        sp;
    int          lcyc;
  } exp_t;
  exp_t q[$];

  gamepad_pmod_rx #(.SYNC_STAGES(2), .NUM_BITS(12), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
    .b(b), .y(y), .select(select), .start(start), .up(up), .down(down), .left(left), .right(right),
    .a(a), .x(x), .l(l), .r(r), .is_present(is_present), .frame_valid(frame_valid),
    .frame_error(frame_error), .start_pressed(start_pressed)
  );

  assign btn = {b, y, select, start, up, down, left, right, a, x, l, r};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bit_out(input logic v, input int hp);
    pmod_data = v;
    repeat (hp) @(negedge clk);
    pmod_clk = 1'b1;
    repeat (hp) @(negedge clk);
    pmod_clk = 1'b0;
  endtask

  task automatic frame(input logic [11:0] v, input int n, input int hp, input exp_t e);
    for (int i = 0; i < n; i++) bit_out(v[11-i], hp);
    e.lcyc = cyc;
    q.push_back(e);
    pmod_latch = 1'b1;
    repeat (hp) @(negedge clk);
    pmod_latch = 1'b0;
    repeat (hp) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_btn"}, 32'(btn), 0);
    chk({name, "_present"}, 32'(is_present), 0);
    chk({name, "_valid"}, 32'(frame_valid), 0);
    chk({name, "_error"}, 32'(frame_error), 0);
    chk({name, "_sp"}, 32'(start_pressed), 0);
  endtask

  // Monitor: every output event is matched against the oldest expected frame
  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_error)) begin
      chk("valid_error_exclusive", 32'(frame_valid & frame_error), 0);
      if (q.size() == 0) begin
        chk("unexpected_event", 32'({frame_valid, frame_error}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("kind_valid", 32'(frame_valid), 32'(e.valid));
        chk("kind_error", 32'(frame_error), 32'(!e.valid));
        chk("buttons", 32'(btn), 32'(e.btn));
        chk("is_present", 32'(is_present), 32'(e.present));
        chk("start_pressed", 32'(start_pressed), 32'(e.sp));
        chk("latency", 32'(cyc - e.lcyc), 4);
      end
    end
  end

  initial begin : stim
    int k;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame(12'h080, 12, 4, '{12'h080, 1'b1, 1'b1, 1'b0, 0});
    frame(12'hFFF, 12, 2, '{12'h000, 1'b0, 1'b1, 1'b0, 0});
    frame(12'h100, 12, 2, '{12'h100, 1'b1, 1'b1, 1'b1, 0});
    frame(12'h000, 11, 2, '{12'h100, 1'b1, 1'b0, 1'b0, 0});
    frame(12'h000, 12, 2, '{12'h000, 1'b1, 1'b1, 1'b0, 0});
    frame(12'h100, 12, 2, '{12'h100, 1'b1, 1'b1, 1'b1, 0});
    frame(12'h100, 12, 2, '{12'h100, 1'b1, 1'b1, 1'b0, 0});
    frame(12'h000, 12, 2, '{12'h000, 1'b1, 1'b1, 1'b0, 0});
    frame(12'h0F0, 12, 2, '{12'h0F0, 1'b1, 1'b1, 1'b0, 0});
    k = 0;
    while (!frame_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wd_frame_seen", 32'(frame_valid), 1);
    repeat (98) @(negedge clk);
    chk("wd_present_98", 32'(is_present), 1);
    chk("wd_btn_98", 32'(btn), 32'h0F0);
    @(negedge clk);
    chk("wd_present_99", 32'(is_present), 0);
    chk("wd_btn_99", 32'(btn), 0);
    repeat (20) @(negedge clk);
    chk("wd_held_present", 32'(is_present), 0);
    frame(12'h0F0, 12, 2, '{12'h0F0, 1'b1, 1'b1, 1'b0, 0});
    for (int i = 0; i < 11; i++) bit_out(1'b0, 2);
    pmod_data = 1'b1;
    repeat (2) @(negedge clk);
    q.push_back('{12'h001, 1'b1, 1'b1, 1'b0, cyc});
    pmod_clk = 1'b1;
    pmod_latch = 1'b1;
    repeat (2) @(negedge clk);
    pmod_clk = 1'b0;
    pmod_latch = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) bit_out(i[0], 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midframe_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame(12'h040, 12, 2, '{12'h040, 1'b1, 1'b1, 1'b0, 0});
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(q.size()), 0);
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
